combo_logic_sweep_ctrl: RTL

- Self-test sequencer for the 3-input Combinational_Logic datapath.
- Drives {A,B,C} through all 8 input combinations and waits a programmable settle time per vector.
- Samples F for each vector, assembles the measured truth table and compares it against an expected table.
- Sits beside the Combinational_Logic instance as its built-in stimulus/check controller; single clock domain.

---
 rtl/combo_logic_sweep_ctrl_pkg.sv | 15 +
 rtl/combo_logic_sweep_ctrl_if.sv | 27 ++
 rtl/combo_logic_sweep_ctrl_settle_timer.sv | 28 ++
 rtl/combo_logic_sweep_ctrl.sv | 94 +++++++++
 4 files changed

// File: rtl/combo_logic_sweep_ctrl_pkg.sv
// Shared types and sizes for the combinational-logic sweep controller.
// Each vector index is {A,B,C}, with A as the most significant bit.
package combo_sweep_pkg;
  localparam int N_VEC = 8;
  localparam int VEC_W = 3;

  typedef logic [VEC_W-1:0] vec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/combo_logic_sweep_ctrl_if.sv
// Bundle between the sweep controller (master) and the host/datapath side
// (slave): stimulus to the datapath, F back from it, and sweep results.
interface combo_sweep_if;
  import combo_sweep_pkg::*;

  logic               start;
  logic               F;
  logic               A;
  logic               B;
  logic               C;
  logic               busy;
  logic               done;
  logic               pass;
  logic [N_VEC-1:0]   truth_table;
  vec_t               fail_index;
  logic [3:0]         fail_count;

  modport master (
    input  start, F,
    output A, B, C, busy, done, pass, truth_table, fail_index, fail_count
  );

  modport slave (
    output start, F,
    input  A, B, C, busy, done, pass, truth_table, fail_index, fail_count
  );
endinterface

// File: rtl/combo_logic_sweep_ctrl_settle_timer.sv
// Per-vector settle counter. It counts while enabled and flags the last
// settle cycle. A setting of 0 cycles behaves like 1.
module settle_timer #(
  parameter int SETTLE_CYCLES = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expire
);
  localparam int EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CW  = $clog2(EFF + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign expire = en && (count_reg == CW'(EFF - 1));
endmodule

// File: rtl/combo_logic_sweep_ctrl.sv
// Built-in self-test sequencer: it walks {A,B,C} through 000..111, samples
// F at the end of each settle window, and grades the measured truth table.
module combo_logic_sweep_ctrl
  import combo_sweep_pkg::*;
#(
  parameter int               SETTLE_CYCLES = 5,
  parameter logic [N_VEC-1:0] EXPECTED      = 8'hE8
) (
  input  logic          clk,
  input  logic          rst_n,
  combo_sweep_if.master bus
);
  state_t           state_reg, state_next;
  vec_t             vec_reg, vec_next;
  logic [N_VEC-1:0] tt_reg, tt_next;
  vec_t             fidx_reg, fidx_next;
  logic [3:0]       fcnt_reg, fcnt_next;
  logic             expire;
  logic             mismatch;

  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_reg != SETTLE),
    .en     (state_reg == SETTLE),
    .expire (expire)
  );

  assign mismatch = (bus.F != EXPECTED[vec_reg]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      vec_reg   <= '0;
      tt_reg    <= '0;
      fidx_reg  <= '0;
      fcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      vec_reg   <= vec_next;
      tt_reg    <= tt_next;
      fidx_reg  <= fidx_next;
      fcnt_reg  <= fcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    vec_next   = vec_reg;
    tt_next    = tt_reg;
    fidx_next  = fidx_reg;
    fcnt_next  = fcnt_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          state_next = SETTLE;
          vec_next   = '0;
          tt_next    = '0;
          fidx_next  = '0;
          fcnt_next  = '0;
        end
      end
      SETTLE: begin
        if (expire) state_next = SAMPLE;
      end
      SAMPLE: begin
        tt_next[vec_reg] = bus.F;
        if (mismatch) begin
          // Only the first mismatch is recorded, so the lowest index wins.
          if (fcnt_reg == 4'd0) fidx_next = vec_reg;
          if (fcnt_reg != 4'(N_VEC)) fcnt_next = fcnt_reg + 4'd1;
        end
        if (vec_reg == vec_t'(N_VEC - 1)) begin
          state_next = DONE;
          vec_next   = '0;
        end else begin
          state_next = SETTLE;
          vec_next   = vec_reg + vec_t'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.A           = vec_reg[2];
  assign bus.B           = vec_reg[1];
  assign bus.C           = vec_reg[0];
  assign bus.busy        = (state_reg == SETTLE) || (state_reg == SAMPLE);
  assign bus.done        = (state_reg == DONE);
  assign bus.pass        = (state_reg == DONE) && (fcnt_reg == 4'd0);
  assign bus.truth_table = tt_reg;
  assign bus.fail_index  = fidx_reg;
  assign bus.fail_count  = fcnt_reg;
endmodule
